vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 199 +++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Recovers pixel position, lock status and a per-frame checksum from a raw VGA sync/pixel stream.
// Latency: 2 clk_pix cycles from input to output; stage 1 registers inputs, stage 2 registers outputs.
// Backpressure: none; the pixel stream is free-running and every output is valid each cycle.
//
// Ports:
//   clk_pix, reset        pixel clock, synchronous active-high reset
//   hsync_in, vsync_in    active-low syncs;  rgb_in  {R,G,B} 4 bits each
//   x, y, de, rgb_out     recovered visible position, valid flag and aligned pixel (zeroed when de=0)
//   locked                timing locked;  frame_done  pulse at each good locked frame boundary
//   frame_sum             16-bit wrapping sum of the last good locked frame's visible pixels
//   err_count             saturating count of cycles with timing errors while training or locked
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_VIS       = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_VIS       = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_pix,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [11:0] rgb_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        de,
  output logic [11:0] rgb_out,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic [7:0]  err_count
);

  localparam int HW = $clog2(2 * H_TOTAL);
  localparam logic [HW-1:0] H_MAX = HW'(2 * H_TOTAL - 1);
  localparam logic [HW-1:0] H_END = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VS  = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_VE  = HW'(H_SYNC + H_BP + H_VIS);
  localparam logic [9:0]    V_END = 10'(V_TOTAL - 1);
  localparam logic [9:0]    V_VS  = 10'(V_SYNC + V_BP);
  localparam logic [9:0]    V_VE  = 10'(V_SYNC + V_BP + V_VIS);
  localparam logic [7:0]    LOCK_N = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {IDLE, TRAIN, LOCKED} state_t;

  // Stage 1
  logic        hs1, hs1_d, vs1, vs1_d;
  logic [11:0] rgb1;

  // Timing state
  logic [HW-1:0] h_cnt;
  logic [9:0]    v_cnt;
  logic          pending;
  logic          h_seen;     // a first hsync fall has been seen (period check armed)
  logic          v_seen;     // a first boundary has been seen (line-count check armed)
  logic          frame_bad;  // an error occurred since the current frame's start boundary
  logic [15:0]   acc;
  state_t        state;
  logic [7:0]    good_cnt;

  // Combinational view of the current stage-1 cycle
  logic          hs_fall, vs_fall, boundary, timeout;
  logic          h_err, v_err, any_err, frame_good, de_nxt;
  logic [HW-1:0] h_nxt;
  logic [9:0]    v_nxt;
  logic [15:0]   acc_sum;

  always_comb begin
    hs_fall  = hs1_d & ~hs1;
    vs_fall  = vs1_d & ~vs1;
    // A vsync fall coinciding with the hsync fall is treated as already pending.
    boundary = hs_fall & (pending | vs_fall);

    // h_nxt is the count of this cycle: 0 on the fall, h_cnt holds the previous cycle's count.
    if (hs_fall)             h_nxt = '0;
    else if (h_cnt == H_MAX) h_nxt = H_MAX;
    else                     h_nxt = h_cnt + HW'(1);

    if (boundary)                  v_nxt = '0;
    else if (!hs_fall)             v_nxt = v_cnt;
    else if (v_cnt == 10'd1023)    v_nxt = v_cnt;
    else                           v_nxt = v_cnt + 10'd1;

    // Timeout fires only on the cycle the counter first reaches saturation.
    timeout    = (h_nxt == H_MAX) && (h_cnt != H_MAX);
    h_err      = (hs_fall && h_seen && (h_cnt != H_END)) || timeout;
    v_err      = boundary && v_seen && (v_cnt != V_END);
    any_err    = h_err || v_err;
    frame_good = !frame_bad && !any_err;

    de_nxt  = (state == LOCKED) &&
              (h_nxt >= H_VS) && (h_nxt < H_VE) &&
              (v_nxt >= V_VS) && (v_nxt < V_VE);
    acc_sum = acc + (de_nxt ? {4'h0, rgb1} : 16'h0000);
  end

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      hs1        <= 1'b0;
      hs1_d      <= 1'b0;
      vs1        <= 1'b0;
      vs1_d      <= 1'b0;
      rgb1       <= '0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      pending    <= 1'b0;
      h_seen     <= 1'b0;
      v_seen     <= 1'b0;
      frame_bad  <= 1'b0;
      acc        <= '0;
      state      <= IDLE;
      good_cnt   <= '0;
      x          <= '0;
      y          <= '0;
      de         <= 1'b0;
      rgb_out    <= '0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      frame_sum  <= '0;
      err_count  <= '0;
    end else begin
      hs1   <= hsync_in;
      hs1_d <= hs1;
      vs1   <= vsync_in;
      vs1_d <= vs1;
      rgb1  <= rgb_in;

      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      if (hs_fall) h_seen <= 1'b1;
      if (boundary) begin
        v_seen  <= 1'b1;
        pending <= 1'b0;
      end else if (vs_fall) begin
        pending <= 1'b1;
      end

      // The boundary cycle belongs to both the ending and the starting frame.
      frame_bad <= boundary ? any_err : (frame_bad | any_err);
      acc       <= boundary ? 16'h0000 : acc_sum;

      // locked mirrors the state being entered so it is aligned with the other stage-2 outputs.
      case (state)
        IDLE: begin
          locked <= 1'b0;
          if (boundary) begin
            state    <= TRAIN;
            good_cnt <= '0;
          end
        end
        TRAIN: begin
          locked <= 1'b0;
          if (boundary) begin
            if (!frame_good) begin
              good_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + 8'd1;
              if (good_cnt + 8'd1 >= LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end
        end
        LOCKED: begin
          if (any_err) begin
            state    <= TRAIN;
            good_cnt <= '0;
            locked   <= 1'b0;
          end else begin
            locked <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      endcase

      if (any_err && (state != IDLE) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;

      de      <= de_nxt;
      x       <= de_nxt ? 10'(h_nxt - H_VS) : 10'd0;
      y       <= de_nxt ? (v_nxt - V_VS) : 10'd0;
      rgb_out <= de_nxt ? rgb1 : 12'h000;

      frame_done <= boundary && (state == LOCKED) && frame_good;
      if (boundary && (state == LOCKED) && frame_good)
        frame_sum <= acc_sum;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Testbench for vga_sync_decoder using a reduced 20x12 timing so whole frames stay short.
// Stimulus pushes expected pixels and frame sums into queues; a negedge monitor pops and compares.
// Status outputs (locked, err_count, reset values) are compared directly at chosen points.
module tb_vga_sync_decoder;

  localparam int H_TOTAL = 20;
  localparam int H_SYNC  = 2;
  localparam int H_BP    = 3;
  localparam int H_VIS   = 12;
  localparam int V_TOTAL = 12;
  localparam int V_SYNC  = 1;
  localparam int V_BP    = 2;
  localparam int V_VIS   = 8;
  localparam int HS = H_SYNC + H_BP;
  localparam int HE = HS + H_VIS;
  localparam int VS = V_SYNC + V_BP;
  localparam int VE = VS + V_VIS;

  logic        clk_pix = 1'b0;
  logic        reset;
  logic        hsync_in, vsync_in;
  logic [11:0] rgb_in;
  logic [9:0]  x, y;
  logic        de;
  logic [11:0] rgb_out;
  logic        locked;
  logic        frame_done;
  logic [15:0] frame_sum;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] pix_q[$];   // {x, y, rgb}
  logic [15:0] sum_q[$];

  vga_sync_decoder #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_VIS(H_VIS),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_VIS(V_VIS),
    .LOCK_FRAMES(2)
  ) dut (
    .clk_pix(clk_pix), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .rgb_in(rgb_in), .x(x), .y(y), .de(de), .rgb_out(rgb_out), .locked(locked),
    .frame_done(frame_done), .frame_sum(frame_sum), .err_count(err_count)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] pix(input int mode, input int vx, input int vy);
    case (mode)
      1:       return 12'hFFF;
      2:       return (vx == 5 && vy == 7) ? 12'hF00 : 12'h000;
      3:       return 12'(vx * 37 + vy * 211 + 5);
      default: return 12'h000;
    endcase
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_pix); #1;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      rgb_in   = 12'h000;
    end
  endtask

  // mode: pixel pattern; de_rows: rows (from row 0) in which the DUT is expected to show de;
  // exp_done: a frame_done with the expected sum follows this frame; stretch_row/stretch lengthen
  // one line; max_rows truncates the frame; mid_err >= 0 checks err_count just before the fall
  // that ends the stretched line.
  task automatic send_frame(input int mode, input int de_rows, input bit exp_done,
                            input int stretch_row, input int stretch,
                            input int max_rows, input int mid_err);
    logic [15:0] sum;
    logic [11:0] p;
    int          len;
    sum = 16'h0000;
    for (int r = 0; r < max_rows; r++) begin
      len = H_TOTAL + ((r == stretch_row) ? stretch : 0);
      for (int c = 0; c < len; c++) begin
        @(posedge clk_pix); #1;
        hsync_in = (c < H_SYNC) ? 1'b0 : 1'b1;
        vsync_in = (r < V_SYNC) ? 1'b0 : 1'b1;
        if (c >= HS && c < HE && r >= VS && r < VE) begin
          p = pix(mode, c - HS, r - VS);
          rgb_in = p;
          if (r < de_rows) begin
            pix_q.push_back({10'(c - HS), 10'(r - VS), p});
            sum = sum + {4'h0, p};
          end
        end else begin
          rgb_in = 12'h5A5;
        end
        if (r == stretch_row && c == len - 2 && mid_err >= 0)
          check("err_count_mid_line", {24'h0, err_count}, mid_err);
      end
    end
    if (exp_done) begin
      case (mode)
        0:       sum_q.push_back(16'h0000);
        1:       sum_q.push_back(16'hFFA0);  // 96 pixels * 0xFFF mod 2^16
        2:       sum_q.push_back(16'h0F00);
        default: sum_q.push_back(sum);
      endcase
    end
  endtask

  task automatic send_line(input int len);
    for (int c = 0; c < len; c++) begin
      @(posedge clk_pix); #1;
      hsync_in = (c < H_SYNC) ? 1'b0 : 1'b1;
      vsync_in = 1'b1;
      rgb_in   = 12'h5A5;
    end
  endtask

  task automatic check_all_zero();
    check("rst_x", {22'h0, x}, 32'h0);
    check("rst_y", {22'h0, y}, 32'h0);
    check("rst_de", {31'h0, de}, 32'h0);
    check("rst_rgb_out", {20'h0, rgb_out}, 32'h0);
    check("rst_locked", {31'h0, locked}, 32'h0);
    check("rst_frame_done", {31'h0, frame_done}, 32'h0);
    check("rst_frame_sum", {16'h0, frame_sum}, 32'h0);
    check("rst_err_count", {24'h0, err_count}, 32'h0);
  endtask

  // Monitor: every de cycle must match the next expected pixel; blank cycles must be zeroed.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk_pix);
      if (de === 1'b1) begin
        if (pix_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL de_unexpected: got x=%0d y=%0d rgb=0x%0h expected no de at %0t",
                   x, y, rgb_out, $time);
        end else begin
          e = pix_q.pop_front();
          check("pixel_xy_rgb", {x, y, rgb_out}, e);
        end
      end else begin
        check("blank_zero", {x, y, rgb_out}, 32'h0);
      end
      if (frame_done === 1'b1) begin
        if (sum_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL frame_done_unexpected: got sum=0x%0h expected no pulse at %0t",
                   frame_sum, $time);
        end else begin
          e = {16'h0, sum_q.pop_front()};
          check("frame_sum", {16'h0, frame_sum}, e);
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    rgb_in   = 12'h000;
    repeat (3) @(posedge clk_pix);
    #1;
    check_all_zero();
    reset = 1'b0;
    idle(5);

    // Acquisition: boundaries 1 and 2 train, boundary 3 locks, boundary 4 gives first frame_done.
    send_frame(0, 0, 1'b0, -1, 0, V_TOTAL, -1);
    check("locked_after_b1", {31'h0, locked}, 32'h0);
    send_frame(0, 0, 1'b0, -1, 0, V_TOTAL, -1);
    check("locked_after_b2", {31'h0, locked}, 32'h0);
    send_frame(1, V_TOTAL, 1'b1, -1, 0, V_TOTAL, -1);
    check("locked_after_b3", {31'h0, locked}, 32'h1);
    check("err_clean", {24'h0, err_count}, 32'h0);
    send_frame(0, V_TOTAL, 1'b1, -1, 0, V_TOTAL, -1);
    send_frame(2, V_TOTAL, 1'b1, -1, 0, V_TOTAL, -1);
    send_frame(3, V_TOTAL, 1'b1, -1, 0, V_TOTAL, -1);
    check("err_clean_locked", {24'h0, err_count}, 32'h0);

    // One line one clock too long: error seen at the start of row 4, lock lost.
    send_frame(0, 4, 1'b0, 3, 1, V_TOTAL, -1);
    check("err_after_stretch", {24'h0, err_count}, 32'h1);
    check("locked_after_stretch", {31'h0, locked}, 32'h0);
    send_frame(0, 0, 1'b0, -1, 0, V_TOTAL, -1);
    send_frame(0, 0, 1'b0, -1, 0, V_TOTAL, -1);
    check("locked_before_relock", {31'h0, locked}, 32'h0);
    send_frame(1, V_TOTAL, 1'b1, -1, 0, V_TOTAL, -1);
    check("locked_relock", {31'h0, locked}, 32'h1);

    // hsync held high beyond 2*H_TOTAL: one timeout error, then one period error on the fall.
    send_frame(0, 6, 1'b0, 5, 30, V_TOTAL, 2);
    check("err_after_timeout", {24'h0, err_count}, 32'h3);
    check("locked_after_timeout", {31'h0, locked}, 32'h0);
    send_frame(0, 0, 1'b0, -1, 0, V_TOTAL, -1);
    send_frame(0, 0, 1'b0, -1, 0, V_TOTAL, -1);

    // Locked frame abandoned by reset partway through.
    send_frame(3, 5, 1'b0, -1, 0, 5, -1);
    idle(3);
    check("locked_before_reset", {31'h0, locked}, 32'h1);
    check("err_before_reset", {24'h0, err_count}, 32'h3);
    check("sum_before_reset", {16'h0, frame_sum}, 32'hFFA0);
    reset = 1'b1;
    @(posedge clk_pix); #1;
    check_all_zero();
    @(posedge clk_pix); #1;
    reset = 1'b0;
    idle(5);

    // Fresh boundary in IDLE counts no error; then a long run of short lines saturates err_count.
    send_frame(0, 0, 1'b0, -1, 0, V_TOTAL, -1);
    check("err_after_reset_frame", {24'h0, err_count}, 32'h0);
    for (int i = 0; i < 310; i++) send_line(H_TOTAL - 1);
    idle(4);
    check("err_saturated", {24'h0, err_count}, 32'hFF);
    check("locked_while_erroring", {31'h0, locked}, 32'h0);

    idle(4);
    check("pix_queue_drained", pix_q.size(), 32'h0);
    check("sum_queue_drained", sum_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
